fetch_sequencer: RTL and testbench

Owns the fetch PC and sequences instruction fetch for the pipelined MIPS core. It issues requests to the instruction memory and hands fetched instructions to the F/D register under the hazard unit's stall control. It applies branch, jump, jr and exception redirects with MIPS delay-slot semantics, taking its targets from the next-PC calculation logic in D.

---
 rtl/fetch_sequencer_pkg.sv | 16 +
 rtl/fetch_sequencer_pc_redirect_slot.sv | 53 +++++
 rtl/fetch_sequencer.sv | 116 +++++++++++
 tb/tb_fetch_sequencer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: FSM encoding, vectors and PC increments.
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_HOLD,
        ST_DRAIN
    } fetch_state_e;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_PC   = 32'h0000_4180;
    localparam logic [31:0] PC_INC4  = 32'd4;
    localparam logic [31:0] PC_INC8  = 32'd8;

endpackage

// File: rtl/fetch_sequencer_pc_redirect_slot.sv
// One-entry redirect slot: prioritises jr > j > br, remembers a target until the
// delay slot is consumed, and bypasses a same-cycle redirect straight to next_pc.
module pc_redirect_slot
    import fetch_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        flush_i,
    input  logic        consume_i,
    input  logic        br_take_i,
    input  logic [31:0] br_pc_i,
    input  logic        j_take_i,
    input  logic [31:0] j_pc_i,
    input  logic        jr_take_i,
    input  logic [31:0] jr_pc_i,
    output logic        redirect_o,
    output logic [31:0] target_o
);

    logic        full_q;
    logic [31:0] target_q;
    logic        req_take;
    logic [31:0] req_pc;

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        req_take = jr_take_i | j_take_i | br_take_i;
        req_pc   = br_pc_i;
        if (jr_take_i) begin
            req_pc = jr_pc_i;
        end else if (j_take_i) begin
            req_pc = j_pc_i;
        end
    end

    // A full slot wins over any new redirect: branch-in-delay-slot is ignored.
    assign redirect_o = full_q | req_take;
    assign target_o   = full_q ? target_q : req_pc;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset || flush_i || consume_i) begin
            full_q <= 1'b0;
        end else if (req_take && !full_q) begin
            full_q   <= 1'b1;
            target_q <= req_pc;
        end
        if (reset) begin
            target_q <= RESET_PC;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch PC owner for the pipelined MIPS core: issues imem requests, delivers to F/D
// under stall control, and applies delay-slot redirects and exception restarts.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        br_take_i,
    input  logic [31:0] br_pc_i,
    input  logic        j_take_i,
    input  logic [31:0] j_pc_i,
    input  logic        jr_take_i,
    input  logic [31:0] jr_pc_i,
    input  logic        exc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc8_o
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  hold_q;
    logic [31:0]  drain_addr_q;

    logic         deliver;
    logic         consume;
    logic         redirect;
    logic [31:0]  target;
    logic [31:0]  next_pc_d;

    assign deliver = !exc_i && (((state_q == ST_FETCH) && imem_ack_i) || (state_q == ST_HOLD));
    assign consume = deliver && !stall_i;

    pc_redirect_slot u_slot (
        .clk        (clk),
        .reset      (reset),
        .flush_i    (exc_i),
        .consume_i  (consume),
        .br_take_i  (br_take_i),
        .br_pc_i    (br_pc_i),
        .j_take_i   (j_take_i),
        .j_pc_i     (j_pc_i),
        .jr_take_i  (jr_take_i),
        .jr_pc_i    (jr_pc_i),
        .redirect_o (redirect),
        .target_o   (target)
    );

    assign next_pc_d = redirect ? target : pc_q + PC_INC4;

    // DRAIN keeps presenting the abandoned address until memory answers it.
    assign imem_req_o  = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
    assign imem_addr_o = (state_q == ST_DRAIN) ? drain_addr_q : pc_q;
    assign valid_o     = deliver;
    assign instr_o     = !deliver ? 32'd0 : (state_q == ST_HOLD) ? hold_q : imem_rdata_i;
    assign pc_o        = pc_q;
    assign pc8_o       = pc_q + PC_INC8;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            hold_q       <= 32'd0;
            drain_addr_q <= RESET_PC;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_FETCH;
                    if (exc_i) begin
                        pc_q <= EXC_PC;
                    end
                end
                ST_FETCH: begin
                    if (exc_i) begin
                        hold_q <= 32'd0;
                        pc_q   <= EXC_PC;
                        if (!imem_ack_i) begin
                            drain_addr_q <= pc_q;
                            state_q      <= ST_DRAIN;
                        end
                    end else if (imem_ack_i) begin
                        if (stall_i) begin
                            hold_q  <= imem_rdata_i;
                            state_q <= ST_HOLD;
                        end else begin
                            pc_q <= next_pc_d;
                        end
                    end
                end
                ST_HOLD: begin
                    if (exc_i) begin
                        hold_q  <= 32'd0;
                        pc_q    <= EXC_PC;
                        state_q <= ST_FETCH;
                    end else if (!stall_i) begin
                        pc_q    <= next_pc_d;
                        state_q <= ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    if (imem_ack_i) begin
                        state_q <= ST_FETCH;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: reset, linear fetch, branch, stall, late-ack
// exception, redirect priority / full slot, and reset from HOLD.
module tb_fetch_sequencer;

    localparam logic [31:0] KEY = 32'hDEAD_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall_i = 1'b0;
    logic        br_take_i = 1'b0;
    logic [31:0] br_pc_i = 32'd0;
    logic        j_take_i = 1'b0;
    logic [31:0] j_pc_i = 32'd0;
    logic        jr_take_i = 1'b0;
    logic [31:0] jr_pc_i = 32'd0;
    logic        exc_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic        valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc8_o;

    logic auto_ack = 1'b1;
    logic man_ack  = 1'b0;
    int   checks   = 0;
    int   errors   = 0;

    always #5 clk = ~clk;

    assign imem_ack_i   = auto_ack ? imem_req_o : man_ack;
    assign imem_rdata_i = imem_addr_o ^ KEY;

    fetch_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .stall_i      (stall_i),
        .br_take_i    (br_take_i),
        .br_pc_i      (br_pc_i),
        .j_take_i     (j_take_i),
        .j_pc_i       (j_pc_i),
        .jr_take_i    (jr_take_i),
        .jr_pc_i      (jr_pc_i),
        .exc_i        (exc_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_rdata_i (imem_rdata_i),
        .valid_o      (valid_o),
        .instr_o      (instr_o),
        .pc_o         (pc_o),
        .pc8_o        (pc8_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are checked at the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic delivered(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, {31'd0, valid_o}, 32'd1);
        chk({tag, "_pc"}, pc_o, pc);
        chk({tag, "_instr"}, instr_o, pc ^ KEY);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_req", {31'd0, imem_req_o}, 32'd0);
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_instr", instr_o, 32'd0);
        chk("rst_pc", pc_o, 32'h0000_3000);
        chk("rst_pc8", pc8_o, 32'h0000_3008);

        // First cycle after reset is IDLE
        tick(); reset = 1'b0;
        @(negedge clk);
        chk("idle_req", {31'd0, imem_req_o}, 32'd0);
        chk("idle_valid", {31'd0, valid_o}, 32'd0);

        // Zero-wait linear fetch
        tick(); @(negedge clk);
        delivered("lin0", 32'h0000_3000);
        chk("lin0_addr", imem_addr_o, 32'h0000_3000);
        tick(); @(negedge clk);
        delivered("lin1", 32'h0000_3004);

        // Branch sampled while 0x3008 (delay slot) is fetched
        tick(); br_take_i = 1'b1; br_pc_i = 32'h0000_3040;
        @(negedge clk);
        delivered("br_slot", 32'h0000_3008);
        tick(); br_take_i = 1'b0;
        @(negedge clk);
        delivered("br_tgt", 32'h0000_3040);
        chk("br_pc8", pc8_o, 32'h0000_3048);

        // Stall for 3 cycles starting on the ack cycle
        tick(); stall_i = 1'b1;
        @(negedge clk);
        delivered("stall_ack", 32'h0000_3044);
        tick(); @(negedge clk);
        delivered("hold1", 32'h0000_3044);
        chk("hold1_req", {31'd0, imem_req_o}, 32'd0);
        tick(); @(negedge clk);
        delivered("hold2", 32'h0000_3044);
        tick(); stall_i = 1'b0;
        @(negedge clk);
        delivered("hold_rel", 32'h0000_3044);
        tick(); @(negedge clk);
        delivered("after_hold", 32'h0000_3048);

        // Exception while waiting on a late ack
        tick(); auto_ack = 1'b0; man_ack = 1'b0; exc_i = 1'b1;
        @(negedge clk);
        chk("exc_valid", {31'd0, valid_o}, 32'd0);
        chk("exc_req", {31'd0, imem_req_o}, 32'd1);
        chk("exc_addr", imem_addr_o, 32'h0000_304C);
        tick(); exc_i = 1'b0;
        @(negedge clk);
        chk("drain1_req", {31'd0, imem_req_o}, 32'd1);
        chk("drain1_addr", imem_addr_o, 32'h0000_304C);
        chk("drain1_valid", {31'd0, valid_o}, 32'd0);
        tick(); @(negedge clk);
        chk("drain2_addr", imem_addr_o, 32'h0000_304C);
        tick(); man_ack = 1'b1;
        @(negedge clk);
        chk("drain_ack_valid", {31'd0, valid_o}, 32'd0);
        chk("drain_ack_addr", imem_addr_o, 32'h0000_304C);
        tick(); auto_ack = 1'b1; man_ack = 1'b0;
        @(negedge clk);
        delivered("exc_vec", 32'h0000_4180);

        // jr and br together (jr wins), then a j while the slot is full
        tick(); stall_i = 1'b1;
        jr_take_i = 1'b1; jr_pc_i = 32'h0000_5000;
        br_take_i = 1'b1; br_pc_i = 32'h0000_6000;
        @(negedge clk);
        delivered("prio_slot", 32'h0000_4184);
        tick(); jr_take_i = 1'b0; br_take_i = 1'b0;
        j_take_i = 1'b1; j_pc_i = 32'h0000_7000;
        @(negedge clk);
        delivered("prio_hold", 32'h0000_4184);
        tick(); stall_i = 1'b0; j_take_i = 1'b0;
        @(negedge clk);
        delivered("prio_rel", 32'h0000_4184);
        tick(); @(negedge clk);
        delivered("prio_tgt", 32'h0000_5000);
        tick(); @(negedge clk);
        delivered("prio_next", 32'h0000_5004);

        // Reset while in HOLD with a pending redirect
        tick(); stall_i = 1'b1; br_take_i = 1'b1; br_pc_i = 32'h0000_6000;
        @(negedge clk);
        delivered("rh_ack", 32'h0000_5008);
        tick(); br_take_i = 1'b0; reset = 1'b1;
        @(negedge clk);
        delivered("rh_hold", 32'h0000_5008);
        tick(); reset = 1'b0; stall_i = 1'b0;
        @(negedge clk);
        chk("rh_idle_valid", {31'd0, valid_o}, 32'd0);
        chk("rh_idle_req", {31'd0, imem_req_o}, 32'd0);
        chk("rh_idle_pc", pc_o, 32'h0000_3000);
        tick(); @(negedge clk);
        delivered("rh_refetch0", 32'h0000_3000);
        tick(); @(negedge clk);
        delivered("rh_refetch1", 32'h0000_3004);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
